// File: rtl/term_pkg.sv
// Shared types and field positions for the south terminal tile.
package term_pkg;

    // Turnaround behaviour selected by the low bits of local config frame 0.
    typedef enum logic [1:0] {
        TURN_OFF  = 2'd0,
        TURN_PASS = 2'd1,
        TURN_ROT  = 2'd2,
        TURN_REG  = 2'd3
    } turn_mode_t;

    // Bit positions of the mode and rotate fields inside config frame 0.
    localparam int MODE_LSB = 0;
    localparam int ROT_LSB  = 2;

endpackage

// File: rtl/s_term_cfg_pipe_if.sv
// Configuration column and wire bundle of the south terminal tile.
interface s_term_cfg_pipe_if #(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int WireCount       = 16,
    parameter int CntW            = 8
);
    logic [FrameBitsPerRow-1:0] FrameData;
    logic [FrameBitsPerRow-1:0] FrameData_O;
    logic [MaxFramesPerCol-1:0] FrameStrobe;
    logic [MaxFramesPerCol-1:0] FrameStrobe_O;
    logic [WireCount-1:0]       S_END;
    logic [WireCount-1:0]       N_BEG;
    logic                       CfgValid;
    logic                       StrobeErr;
    logic [CntW-1:0]            FrameCount;

    // Tile side: consumes the column and south wires, produces the rest.
    modport slave (
        input  FrameData, FrameStrobe, S_END,
        output FrameData_O, FrameStrobe_O, N_BEG, CfgValid, StrobeErr, FrameCount
    );

    // Environment side.
    modport master (
        output FrameData, FrameStrobe, S_END,
        input  FrameData_O, FrameStrobe_O, N_BEG, CfgValid, StrobeErr, FrameCount
    );
endinterface

// File: rtl/cfg_pipe_stage.sv
// One retiming register for the packed {FrameStrobe, FrameData} column.
module cfg_pipe_stage #(
    parameter int W = 52
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    // Register the column word; cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_q <= '0;
        else     r_q <= i_d;
    end

    assign o_q = r_q;
endmodule

// File: rtl/clk_buf.sv
// Clock buffer cell; a plain wire in RTL, swapped for a library cell at implementation.
module clk_buf (
    input  logic i_clk,
    output logic o_clk
);
    assign o_clk = i_clk;
endmodule

// File: rtl/s_term_cfg_pipe.sv
// South terminal tile: retimed config column, local frame capture,
// multi-hot strobe detection and a configurable S->N wire turnaround.
module s_term_cfg_pipe
    import term_pkg::*;
#(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int PipeStages      = 1,
    parameter int WireCount       = 16,
    parameter int CfgFrameBase    = 0,
    parameter int NumCfgFrames    = 2,
    parameter int CntW            = 8
) (
    input  logic              UserCLK,
    input  logic              Rst,
    output logic              UserCLKo,
    s_term_cfg_pipe_if.slave  bus
);
    localparam int W    = MaxFramesPerCol + FrameBitsPerRow;
    localparam int RotW = $clog2(WireCount);
    localparam logic [CntW-1:0] CNT_MAX = '1;

    clk_buf u_clk_buf (.i_clk(UserCLK), .o_clk(UserCLKo));

    // ---------------- config column pipe ----------------
    logic [W-1:0] w_pipe [0:PipeStages];
    assign w_pipe[0] = {bus.FrameStrobe, bus.FrameData};

    generate
        for (genvar gi = 0; gi < PipeStages; gi++) begin : g_stage
            cfg_pipe_stage #(.W(W)) u_stage (
                .clk (UserCLK),
                .rst (Rst),
                .i_d (w_pipe[gi]),
                .o_q (w_pipe[gi+1])
            );
        end
    endgenerate

    assign bus.FrameStrobe_O = w_pipe[PipeStages][W-1:FrameBitsPerRow];
    assign bus.FrameData_O   = w_pipe[PipeStages][FrameBitsPerRow-1:0];

    // ---------------- local capture ----------------
    logic                       w_onehot;
    logic                       w_multi;
    logic [NumCfgFrames-1:0]    w_wr;
    logic [NumCfgFrames-1:0]    r_written;
    logic [FrameBitsPerRow-1:0] r_cfg [NumCfgFrames];
    logic                       r_cfg_valid;
    logic                       r_err;
    logic [CntW-1:0]            r_cnt;

    // Captures happen only for a single-hot strobe that lands in our window.
    assign w_onehot = $onehot(bus.FrameStrobe);
    assign w_multi  = ($countones(bus.FrameStrobe) > 1);
    assign w_wr     = bus.FrameStrobe[CfgFrameBase +: NumCfgFrames] & {NumCfgFrames{w_onehot}};

    generate
        for (genvar gi = 0; gi < NumCfgFrames; gi++) begin : g_cfg
            // Frame register and its written flag; the last write wins.
            always_ff @(posedge UserCLK or posedge Rst) begin
                if (Rst) begin
                    r_cfg[gi]     <= '0;
                    r_written[gi] <= 1'b0;
                end else if (w_wr[gi]) begin
                    r_cfg[gi]     <= bus.FrameData;
                    r_written[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Valid flag looks ahead at this edge's write so it rises with the final first write.
    always_ff @(posedge UserCLK or posedge Rst) begin
        if (Rst) r_cfg_valid <= 1'b0;
        else     r_cfg_valid <= &(r_written | w_wr);
    end

    // Saturating count of accepted local writes.
    always_ff @(posedge UserCLK or posedge Rst) begin
        if (Rst)                         r_cnt <= '0;
        else if (|w_wr && r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
    end

    // Sticky multi-hot strobe flag.
    always_ff @(posedge UserCLK or posedge Rst) begin
        if (Rst)          r_err <= 1'b0;
        else if (w_multi) r_err <= 1'b1;
    end

    assign bus.CfgValid   = r_cfg_valid;
    assign bus.StrobeErr  = r_err;
    assign bus.FrameCount = r_cnt;

    // ---------------- turnaround ----------------
    turn_mode_t                 w_mode;
    logic [RotW-1:0]            w_rot;
    logic [2*WireCount-1:0]     w_dbl;
    logic [WireCount-1:0]       r_s_end;
    logic [WireCount-1:0]       w_n_beg;
    logic                       w_unused_cfg;

    assign w_mode = turn_mode_t'(r_cfg[0][MODE_LSB +: 2]);
    assign w_rot  = r_cfg[0][ROT_LSB +: RotW];
    // Rotate-left via a doubled word; power-of-two width makes the wrap free.
    assign w_dbl  = {bus.S_END, bus.S_END} << w_rot;

    // Reserved config bits are kept for simulation visibility only.
    always_comb begin
        w_unused_cfg = ^r_cfg[0][FrameBitsPerRow-1:ROT_LSB+RotW];
        for (int k = 1; k < NumCfgFrames; k++) w_unused_cfg = w_unused_cfg ^ (^r_cfg[k]);
    end

    // Registered turnaround path; loads only while REG mode is active, else holds.
    always_ff @(posedge UserCLK or posedge Rst) begin
        if (Rst)                    r_s_end <= '0;
        else if (w_mode == TURN_REG) r_s_end <= bus.S_END;
    end

    // Output mux; forced low while reset is asserted.
    always_comb begin
        w_n_beg = '0;
        case (w_mode)
            TURN_OFF:  w_n_beg = '0;
            TURN_PASS: w_n_beg = bus.S_END;
            TURN_ROT:  w_n_beg = w_dbl[2*WireCount-1:WireCount];
            TURN_REG:  w_n_beg = r_s_end;
            default:   w_n_beg = '0;
        endcase
        if (Rst) w_n_beg = '0;
    end

    assign bus.N_BEG = w_n_beg;
endmodule

// File: tb/tb_s_term_cfg_pipe.sv
// Directed bench for the south terminal tile with a two-stage config pipe.
module tb_s_term_cfg_pipe;
    logic UserCLK = 1'b0;
    logic Rst     = 1'b1;
    logic UserCLKo;

    int n_cmp = 0;
    int n_err = 0;

    s_term_cfg_pipe_if #(.FrameBitsPerRow(32), .MaxFramesPerCol(20), .WireCount(16), .CntW(8)) bus ();

    s_term_cfg_pipe #(
        .FrameBitsPerRow(32), .MaxFramesPerCol(20), .PipeStages(2), .WireCount(16),
        .CfgFrameBase(0), .NumCfgFrames(2), .CntW(8)
    ) dut (
        .UserCLK  (UserCLK),
        .Rst      (Rst),
        .UserCLKo (UserCLKo),
        .bus      (bus)
    );

    always #5 UserCLK = ~UserCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge UserCLK);
        #1;
    endtask

    // One-cycle frame write, strobe dropped afterwards.
    task automatic wr(input logic [19:0] stb, input logic [31:0] data);
        bus.FrameStrobe = stb;
        bus.FrameData   = data;
        tick();
        bus.FrameStrobe = '0;
        bus.FrameData   = '0;
    endtask

    initial begin
        bus.FrameData   = 32'hA5A5_0001;
        bus.FrameStrobe = 20'h1;
        bus.S_END       = 16'h1234;
        // 1. reset state and pipe latency
        tick(); tick();
        chk("rst_fdo",   bus.FrameData_O, 32'h0);
        chk("rst_fso",   bus.FrameStrobe_O, 32'h0);
        chk("rst_nbeg",  bus.N_BEG, 32'h0);
        chk("rst_valid", bus.CfgValid, 32'h0);
        chk("rst_err",   bus.StrobeErr, 32'h0);
        chk("rst_cnt",   bus.FrameCount, 32'h0);
        bus.FrameData = '0; bus.FrameStrobe = '0; Rst = 1'b0;
        tick();
        wr(20'h1, 32'hA5A5_0001);
        chk("pipe_e1_fdo", bus.FrameData_O, 32'h0);
        tick();
        chk("pipe_e2_fdo", bus.FrameData_O, 32'hA5A5_0001);
        chk("pipe_e2_fso", bus.FrameStrobe_O, 32'h1);
        tick();
        chk("pipe_e3_fdo", bus.FrameData_O, 32'h0);
        chk("pipe_e3_fso", bus.FrameStrobe_O, 32'h0);

        // 2. fresh reset, fill both frames
        Rst = 1'b1; tick(); Rst = 1'b0; tick();
        wr(20'h1, 32'h0000_0001);
        chk("wr0_valid", bus.CfgValid, 32'h0);
        chk("wr0_cnt",   bus.FrameCount, 32'h1);
        wr(20'h2, 32'hDEAD_BEEF);
        chk("wr1_valid", bus.CfgValid, 32'h1);
        chk("wr1_cnt",   bus.FrameCount, 32'h2);
        bus.S_END = 16'h1234; #1;
        chk("pass_nbeg", bus.N_BEG, 32'h1234);

        // 3. rotate mode
        wr(20'h1, 32'h0000_0012);
        bus.S_END = 16'h8001; #1;
        chk("rot4_nbeg", bus.N_BEG, 32'h0018);
        wr(20'h1, 32'h0000_0002);
        chk("rot0_nbeg", bus.N_BEG, 32'h8001);

        // 4. multi-hot strobe
        wr(20'h3, 32'hFFFF_FFFF);
        chk("mh_err",  bus.StrobeErr, 32'h1);
        chk("mh_cnt",  bus.FrameCount, 32'h4);
        chk("mh_nbeg", bus.N_BEG, 32'h8001);
        tick();
        chk("mh_fso", bus.FrameStrobe_O, 32'h3);
        chk("mh_fdo", bus.FrameData_O, 32'hFFFF_FFFF);
        wr(20'h1, 32'h0000_0001);
        chk("mh_next_cnt", bus.FrameCount, 32'h5);
        chk("mh_sticky",   bus.StrobeErr, 32'h1);
        chk("mh_next_nbeg", bus.N_BEG, 32'h8001);

        // 5. registered mode and mid-stream reset
        wr(20'h1, 32'h0000_0003);
        bus.S_END = 16'h00FF; #1;
        chk("reg_hold0", bus.N_BEG, 32'h0);
        tick();
        chk("reg_ff",    bus.N_BEG, 32'h00FF);
        bus.S_END = 16'hFF00; #1;
        chk("reg_lag",   bus.N_BEG, 32'h00FF);
        tick();
        chk("reg_ff00",  bus.N_BEG, 32'hFF00);
        Rst = 1'b1; #1;
        chk("mid_rst_nbeg",  bus.N_BEG, 32'h0);
        chk("mid_rst_cnt",   bus.FrameCount, 32'h0);
        chk("mid_rst_err",   bus.StrobeErr, 32'h0);
        chk("mid_rst_valid", bus.CfgValid, 32'h0);
        tick(); Rst = 1'b0; tick();
        chk("post_rst_off", bus.N_BEG, 32'h0);
        wr(20'h1, 32'h0000_0003);
        chk("reg_cleared", bus.N_BEG, 32'h0);

        // 6. saturation and non-local strobe
        bus.FrameStrobe = 20'h2;
        for (int i = 0; i < 300; i++) begin
            bus.FrameData = i;
            tick();
        end
        bus.FrameStrobe = '0; bus.FrameData = '0;
        chk("sat_cnt",   bus.FrameCount, 32'hFF);
        chk("sat_valid", bus.CfgValid, 32'h1);
        bus.S_END = 16'h5A5A;
        tick();
        chk("reg_still", bus.N_BEG, 32'h5A5A);
        wr(20'h20, 32'h0000_0001);
        chk("nl_cnt", bus.FrameCount, 32'hFF);
        bus.S_END = 16'h0F0F; #1;
        chk("nl_mode", bus.N_BEG, 32'h5A5A);
        tick();
        chk("nl_fso", bus.FrameStrobe_O, 32'h20);
        chk("nl_fdo", bus.FrameData_O, 32'h1);
        chk("nl_err", bus.StrobeErr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
